control_block: RTL
==================

// Module: control_block
// PURPOSE
// - Test sequencer directly upstream of transmitter_block. On start, issues the CSR-programmed number of memory
//   transactions (address + read/write type) over a valid/ready handshake.
// - Waits for the transmitter to drain, then reports done/error and the count of transactions issued.
// PARAMETERS (rtl_settings_pkg constants, not module parameters)
// - ADDR_W    : per pkg : width of the transaction address
// - ADDR_B_W  : per pkg : byte-offset bits within one data word
// - ADDR_TYPE : per pkg : "BYTE" or "WORD" addressing
// - AMM_BURST_W : per pkg : burstcount width; the CSR burst field is AMM_BURST_W-1 bits
// PORTS
// - clk_i            in   1           : system clock
// - rst_i            in   1           : asynchronous reset, active-high
// - test_param_i     in   [CSR_SET_DATA:CSR_TEST_PARAM][31:0] : CSR snapshot
// - start_test_i     in   1           : start pulse, honoured only in IDLE
// - trans_valid_o    out  1           : transaction request valid
// - trans_addr_o     out  ADDR_W      : transaction address
// - trans_type_o     out  1           : 0 = write, 1 = read
// - trans_ready_i    in   1           : transmitter accepts the request
// - trans_busy_i     in   1           : transmitter holding or executing work
// - cmp_error_i      in   1           : compare mismatch
// - test_done_o      out  1           : one-cycle pulse when the test ends
// - test_error_o     out  1           : sticky, set on cmp_error_i, cleared on start
// - trans_cnt_o      out  16          : accepted transactions (a write/read pair counts as 1)
// BEHAVIOUR
// - CSR fields, latched at the start pulse:
//   - TEST_PARAM[15:14] test_mode (WRITE_ONLY, READ_ONLY, WRITE_AND_CHECK)
//   - [11:10] addr_mode (FIX_ADDR=0, RND_ADDR=1, RUN_ADDR=2; 3 is treated as FIX)
//   - [AMM_BURST_W-2:0] burst
//   - [31:16] trans_num; 0 ends the test immediately with a done pulse
//   - CSR_SET_ADDR[ADDR_W-1:0] is the base address.
// - Reset: IDLE. trans_valid_o=0, trans_addr_o=0, trans_type_o=0, test_done_o=0, test_error_o=0, trans_cnt_o=0,
//   LFSR=32'hFFFF_FFFF.
// - FSM: IDLE -> ISSUE on start_test_i.
//   - ISSUE -> WAIT when the last request is accepted.
//   - WAIT -> IDLE when trans_busy_i=0 for one cycle; test_done_o pulses that cycle.
// - Handshake: a request is accepted when trans_valid_o && trans_ready_i. While valid and not accepted,
//   trans_addr_o and trans_type_o hold stable.
// - The next request is presented the cycle after acceptance (registered outputs; at most one request per 2 cycles).
// - WRITE_AND_CHECK: each address is issued as a write then a read to the same address.
//   trans_cnt_o increments on read acceptance only.
// - Addressing, selected after each completed unit:
//   - FIX: base address always.
//   - RUN: base + k*step, where step = (burst+1) << ADDR_B_W for BYTE and burst+1 for WORD.
//     Arithmetic is modulo 2^ADDR_W (wrap-around; no saturation).
//   - RND: LFSR[ADDR_W-1:0], advanced once per unit. LFSR taps x^32+x^22+x^2+x+1.
// - cmp_error_i in ISSUE: set test_error_o, deassert trans_valid_o next cycle, go to WAIT (abort).
//   In any other state it only sets test_error_o.
// - A start pulse outside IDLE is ignored. test_error_o and trans_cnt_o clear on an accepted start.
// - Same-cycle acceptance and cmp_error_i: the acceptance is counted, then the abort is taken.
// - Reset mid-test: immediate return to reset values; no done pulse.
// STRUCTURE
// - Add to rtl_settings_pkg:
//   - addr_mode_t enum
//   - ctrl_state_t {IDLE, ISSUE, WAIT}
//   - CSR_SET_ADDR index, located between CSR_TEST_PARAM and CSR_SET_DATA
//   - CSR field bit positions as localparams
// - Sub-module addr_gen_block: addr_mode, base, step, LFSR, next_stb -> addr.
// - FSM, counters and handshake stay in the top level.
// TESTING
// - WRITE_ONLY, RUN, base=0x100, burst=3, BYTE, ADDR_B_W=2, trans_num=4, ready=1
//   -> writes to 0x100, 0x110, 0x120, 0x130; trans_cnt=4; done pulse once.
// - WRITE_AND_CHECK, FIX, base=0x40, trans_num=2
//   -> sequence W@0x40, R@0x40, W@0x40, R@0x40; trans_cnt=2.
// - RUN with base=2^ADDR_W-0x10, step 0x10, trans_num=3
//   -> addresses wrap: 0x..F0, 0x000, 0x010.
// - ready held low 5 cycles with valid high -> addr/type stable throughout; accepted once.
// - cmp_error_i pulsed after the 2nd acceptance of trans_num=10
//   -> valid drops; test_error_o=1; done after trans_busy_i falls; trans_cnt=2.
// - trans_num=0 -> done pulse with no valid; start during ISSUE ignored; rst_i mid-ISSUE -> all outputs reset.

Source files
------------

// File: rtl/rtl_settings_pkg.sv
// rtl_settings_pkg: shared widths, CSR layout and enums for the traffic test sequencer.
package rtl_settings_pkg;

    localparam int ADDR_W      = 16;
    localparam int ADDR_B_W    = 2;
    localparam     ADDR_TYPE   = "BYTE";
    localparam int AMM_BURST_W = 8;
    localparam int BURST_W     = AMM_BURST_W - 1;

    localparam int CSR_TEST_PARAM = 0;
    localparam int CSR_SET_ADDR   = 1;
    localparam int CSR_SET_DATA   = 2;

    localparam int TP_TEST_MODE_LSB = 14;
    localparam int TP_ADDR_MODE_LSB = 10;
    localparam int TP_TRANS_NUM_LSB = 16;

    localparam logic [31:0] LFSR_INIT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        WRITE_ONLY      = 2'd0,
        READ_ONLY       = 2'd1,
        WRITE_AND_CHECK = 2'd2
    } test_mode_t;

    typedef enum logic [1:0] {
        FIX_ADDR = 2'd0,
        RND_ADDR = 2'd1,
        RUN_ADDR = 2'd2
    } addr_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } ctrl_state_t;

    // x^32 + x^22 + x^2 + x + 1, shifting towards the MSB
    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    function automatic logic [ADDR_W-1:0] addr_step(input logic [BURST_W-1:0] burst);
        logic [ADDR_W-1:0] s;
        s = ADDR_W'(burst) + ADDR_W'(1);
        return (ADDR_TYPE == "BYTE") ? s << ADDR_B_W : s;
    endfunction

endpackage

// File: rtl/addr_gen_block.sv
// addr_gen_block: produces the address of the current unit; latches mode/step on load,
// moves to the next address on each completed unit.
module addr_gen_block
    import rtl_settings_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              next_stb_i,
    input  addr_mode_t        addr_mode_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] step_i,
    output logic [ADDR_W-1:0] addr_o
);

    addr_mode_t        mode_q;
    logic [ADDR_W-1:0] step_q;
    logic [31:0]       lfsr;
    logic [31:0]       lfsr_nxt;

    assign lfsr_nxt = lfsr_next(lfsr);

    // LFSR persists across tests; only reset reseeds it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q <= FIX_ADDR;
            step_q <= '0;
            lfsr   <= LFSR_INIT;
            addr_o <= '0;
        end else if (load_i) begin
            mode_q <= addr_mode_i;
            step_q <= step_i;
            addr_o <= (addr_mode_i == RND_ADDR) ? lfsr[ADDR_W-1:0] : base_i;
        end else if (next_stb_i) begin
            if (mode_q == RND_ADDR)
                lfsr <= lfsr_nxt;
            addr_o <= (mode_q == RUN_ADDR) ? addr_o + step_q :
                      (mode_q == RND_ADDR) ? lfsr_nxt[ADDR_W-1:0] : addr_o;
        end
    end

endmodule

// File: rtl/control_block.sv
// control_block: test sequencer that issues the CSR-programmed number of transactions
// over valid/ready, waits for the transmitter to drain, then reports done/error/count.
module control_block
    import rtl_settings_pkg::*;
(
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [CSR_SET_DATA:CSR_TEST_PARAM][31:0] test_param_i,
    input  logic                                     start_test_i,
    output logic                                     trans_valid_o,
    output logic [ADDR_W-1:0]                        trans_addr_o,
    output logic                                     trans_type_o,
    input  logic                                     trans_ready_i,
    input  logic                                     trans_busy_i,
    input  logic                                     cmp_error_i,
    output logic                                     test_done_o,
    output logic                                     test_error_o,
    output logic [15:0]                              trans_cnt_o
);

    ctrl_state_t  state;
    ctrl_state_t  state_nxt;
    test_mode_t   mode_q;
    logic [15:0]  num_q;
    test_mode_t   csr_mode;
    addr_mode_t   csr_amode;
    logic [15:0]  csr_num;
    logic [BURST_W-1:0] csr_burst;
    logic         start_acc;
    logic         accept;
    logic         unit_done;
    logic         last;
    logic         unused_csr;

    assign csr_mode  = test_mode_t'(test_param_i[CSR_TEST_PARAM][TP_TEST_MODE_LSB +: 2]);
    assign csr_amode = addr_mode_t'(test_param_i[CSR_TEST_PARAM][TP_ADDR_MODE_LSB +: 2]);
    assign csr_num   = test_param_i[CSR_TEST_PARAM][TP_TRANS_NUM_LSB +: 16];
    assign csr_burst = test_param_i[CSR_TEST_PARAM][BURST_W-1:0];
    assign unused_csr = ^test_param_i;

    assign start_acc = (state == IDLE) && start_test_i;
    assign accept    = trans_valid_o && trans_ready_i;
    // a unit is one write, one read, or a write/read pair ending on the read
    assign unit_done = accept && ((mode_q != WRITE_AND_CHECK) || trans_type_o);
    assign last      = unit_done && (trans_cnt_o + 16'd1 == num_q);

    addr_gen_block u_addr_gen (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (start_acc),
        .next_stb_i  (unit_done),
        .addr_mode_i (csr_amode),
        .base_i      (test_param_i[CSR_SET_ADDR][ADDR_W-1:0]),
        .step_i      (addr_step(csr_burst)),
        .addr_o      (trans_addr_o)
    );

    always_comb begin
        state_nxt   = state;
        test_done_o = 1'b0;
        case (state)
            IDLE:    if (start_test_i) state_nxt = (csr_num == 16'd0) ? WAIT : ISSUE;
            ISSUE:   if (last || cmp_error_i) state_nxt = WAIT;
            WAIT: begin
                if (!trans_busy_i) begin
                    state_nxt   = IDLE;
                    test_done_o = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            mode_q        <= WRITE_ONLY;
            num_q         <= '0;
            trans_valid_o <= 1'b0;
            trans_type_o  <= 1'b0;
            trans_cnt_o   <= '0;
            test_error_o  <= 1'b0;
        end else begin
            state         <= state_nxt;
            test_error_o  <= (start_acc ? 1'b0 : test_error_o) | cmp_error_i;
            // drops for one cycle after each acceptance, and on leaving ISSUE
            trans_valid_o <= (state_nxt == ISSUE) && !accept;
            if (start_acc) begin
                mode_q       <= csr_mode;
                num_q        <= csr_num;
                trans_cnt_o  <= '0;
                trans_type_o <= (csr_mode == READ_ONLY);
            end
            if (unit_done)
                trans_cnt_o <= trans_cnt_o + 16'd1;
            if (accept)
                trans_type_o <= (mode_q == WRITE_AND_CHECK) ? !trans_type_o : (mode_q == READ_ONLY);
        end
    end

endmodule
